// File: rtl/eth_header_parser.sv
// Ethernet L2 header extractor for the 64-bit packet bus: captures MACs, optional
// 802.1Q tag and EtherType, counts bytes and flags framing problems; one result per packet.
module eth_header_parser #(
  parameter logic [15:0] VLAN_TPID = 16'h8100,
  parameter int unsigned MIN_LEN   = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [63:0] data,
  input  logic [7:0]  byte_enable,
  input  logic        sop,
  input  logic        eop,
  output logic        pkt_done,
  output logic [47:0] dst_mac,
  output logic [47:0] src_mac,
  output logic        vlan_present,
  output logic [15:0] vlan_tci,
  output logic [15:0] ethertype,
  output logic [15:0] pkt_len,
  output logic        err_runt,
  output logic        err_trunc,
  output logic        err_be,
  output logic        framing_err
);

  typedef enum logic [1:0] {IDLE, W1, W2, BODY} state_t;

  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] tpid;
    logic [15:0] tci;
    logic [15:0] inner;
    logic [15:0] len;
    logic        be_err;
  } work_t;

  localparam logic [15:0] MIN_U = 16'(MIN_LEN);
  localparam logic [15:0] MIN_T = 16'(MIN_LEN + 4);

  function automatic logic be_contig(input logic [7:0] be);
    case (be)
      8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF: be_contig = 1'b1;
      default:                                               be_contig = 1'b0;
    endcase
  endfunction

  state_t      state_q, state_d;
  work_t       work_q, work_d, start_w, fin_src;
  logic        pend_q, pend_d;
  logic        fin, fin_use_q, trunc, ferr_d;
  logic [7:0]  be_eff;
  logic [63:0] mdata;
  logic [3:0]  cnt;
  logic        be_bad;
  logic [16:0] sum;
  logic [15:0] len_acc;

  // Absent bytes are zeroed up front so every field sourced from them reads 0.
  always_comb begin
    be_eff = eop ? byte_enable : 8'hFF;
    mdata  = '0;
    cnt    = '0;
    for (int i = 0; i < 8; i++) begin
      mdata[i*8 +: 8] = be_eff[i] ? data[i*8 +: 8] : 8'h00;
      cnt             = cnt + {3'b000, be_eff[i]};
    end
    be_bad  = eop & ~be_contig(byte_enable);
    sum     = {1'b0, work_q.len} + {13'b0, cnt};
    len_acc = sum[16] ? 16'hFFFF : sum[15:0];

    start_w             = '0;
    start_w.dst         = mdata[63:16];
    start_w.src[47:32]  = mdata[15:0];
    start_w.len         = {12'b0, cnt};
    start_w.be_err      = be_bad;
  end

  // A pending result always comes from the working registers, which also serve
  // a truncated packet; a normal eop result comes from the updated values.
  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    pend_d    = 1'b0;
    fin       = pend_q;
    fin_use_q = pend_q;
    trunc     = 1'b0;
    ferr_d    = 1'b0;
    if (valid) begin
      case (state_q)
        IDLE: begin
          if (sop) begin
            work_d  = start_w;
            state_d = eop ? IDLE : W1;
            if (eop) begin
              if (pend_q) pend_d = 1'b1;
              else        fin    = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
          end
        end
        default: begin
          if (sop) begin
            fin       = 1'b1;
            fin_use_q = 1'b1;
            trunc     = 1'b1;
            work_d    = start_w;
            state_d   = eop ? IDLE : W1;
            pend_d    = eop;
          end else begin
            work_d.len    = len_acc;
            work_d.be_err = work_q.be_err | be_bad;
            case (state_q)
              W1: begin
                work_d.src[31:0] = mdata[63:32];
                work_d.tpid      = mdata[31:16];
                if (mdata[31:16] == VLAN_TPID) begin
                  work_d.tci = mdata[15:0];
                  state_d    = W2;
                end else begin
                  state_d    = BODY;
                end
              end
              W2: begin
                work_d.inner = mdata[63:48];
                state_d      = BODY;
              end
              default: state_d = BODY;
            endcase
            if (eop) begin
              fin     = 1'b1;
              state_d = IDLE;
            end
          end
        end
      endcase
    end
    fin_src = fin_use_q ? work_q : work_d;
  end

  logic        r_short, r_tag;
  logic        done_q, vlan_q, runt_q, trunc_q, be_q, ferr_q;
  logic [47:0] dst_q, src_q;
  logic [15:0] tci_q, et_q, len_q;

  always_comb begin
    r_short = fin_src.len < MIN_U;
    r_tag   = ~r_short & (fin_src.tpid == VLAN_TPID);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      dst_q   <= '0;
      src_q   <= '0;
      vlan_q  <= 1'b0;
      tci_q   <= '0;
      et_q    <= '0;
      len_q   <= '0;
      runt_q  <= 1'b0;
      trunc_q <= 1'b0;
      be_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      pend_q  <= pend_d;
      done_q  <= fin;
      ferr_q  <= ferr_d;
      if (fin) begin
        dst_q   <= fin_src.dst;
        src_q   <= fin_src.src;
        vlan_q  <= r_tag;
        tci_q   <= r_tag ? fin_src.tci : 16'h0;
        et_q    <= r_short ? 16'h0 : (r_tag ? fin_src.inner : fin_src.tpid);
        len_q   <= fin_src.len;
        runt_q  <= r_short | (r_tag & (fin_src.len < MIN_T));
        trunc_q <= trunc;
        be_q    <= fin_src.be_err;
      end
    end
  end

  assign pkt_done     = done_q;
  assign dst_mac      = dst_q;
  assign src_mac      = src_q;
  assign vlan_present = vlan_q;
  assign vlan_tci     = tci_q;
  assign ethertype    = et_q;
  assign pkt_len      = len_q;
  assign err_runt     = runt_q;
  assign err_trunc    = trunc_q;
  assign err_be       = be_q;
  assign framing_err  = ferr_q;

endmodule

// File: tb/tb_eth_header_parser.sv
// Directed bench for eth_header_parser: hand-built packets, results checked the
// cycle after each eop / truncating sop.
module tb_eth_header_parser;

  logic        clk, rst, valid, sop, eop;
  logic [63:0] data;
  logic [7:0]  byte_enable;
  logic        pkt_done, vlan_present, err_runt, err_trunc, err_be, framing_err;
  logic [47:0] dst_mac, src_mac;
  logic [15:0] vlan_tci, ethertype, pkt_len;

  eth_header_parser dut (
    .clk(clk), .rst(rst), .valid(valid), .data(data), .byte_enable(byte_enable),
    .sop(sop), .eop(eop), .pkt_done(pkt_done), .dst_mac(dst_mac), .src_mac(src_mac),
    .vlan_present(vlan_present), .vlan_tci(vlan_tci), .ethertype(ethertype),
    .pkt_len(pkt_len), .err_runt(err_runt), .err_trunc(err_trunc), .err_be(err_be),
    .framing_err(framing_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] pb [0:127];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [63:0] d, input logic [7:0] be, input logic s, input logic e);
    @(negedge clk);
    valid = 1'b1; data = d; byte_enable = be; sop = s; eop = e;
  endtask

  task automatic idle();
    @(negedge clk);
    valid = 1'b0; sop = 1'b0; eop = 1'b0; data = '0; byte_enable = '0;
  endtask

  task automatic send(input int n);
    int nb;
    logic [63:0] d;
    logic [7:0] m;
    nb = (n + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < 8; k++) d[63-8*k -: 8] = (8*b + k < n) ? pb[8*b + k] : 8'h00;
      m = 8'hFF;
      if (b == nb - 1 && (n % 8) != 0) m = m << (8 - (n % 8));
      beat(d, m, b == 0, b == nb - 1);
    end
  endtask

  task automatic fill_base();
    for (int i = 0; i < 128; i++) pb[i] = 8'(i);
    {pb[0], pb[1], pb[2], pb[3], pb[4], pb[5]}    = 48'h112233445566;
    {pb[6], pb[7], pb[8], pb[9], pb[10], pb[11]}  = 48'hAABBCCDDEEFF;
    {pb[12], pb[13]} = 16'h0800;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; sop = 1'b0; eop = 1'b0; data = '0; byte_enable = '0;
    repeat (2) @(negedge clk);
    chk("rst_done", pkt_done, 0);
    chk("rst_len", pkt_len, 0);
    chk("rst_dst", dst_mac, 0);
    chk("rst_ferr", framing_err, 0);
    rst = 1'b0;
    idle();

    // untagged 64 bytes
    fill_base();
    send(64);
    chk("u64_pre_done", pkt_done, 0);
    idle();
    chk("u64_done", pkt_done, 1);
    chk("u64_len", pkt_len, 64);
    chk("u64_dst", dst_mac, 48'h112233445566);
    chk("u64_src", src_mac, 48'hAABBCCDDEEFF);
    chk("u64_et", ethertype, 16'h0800);
    chk("u64_vlan", vlan_present, 0);
    chk("u64_errs", {err_runt, err_trunc, err_be}, 0);
    idle();
    chk("u64_done_clr", pkt_done, 0);

    // tagged 67 bytes
    {pb[12], pb[13], pb[14], pb[15], pb[16], pb[17]} = 48'h8100_6064_86DD;
    send(67);
    idle();
    chk("t67_done", pkt_done, 1);
    chk("t67_vlan", vlan_present, 1);
    chk("t67_tci", vlan_tci, 16'h6064);
    chk("t67_et", ethertype, 16'h86DD);
    chk("t67_len", pkt_len, 67);
    chk("t67_runt", err_runt, 0);

    // 13-byte runt
    fill_base();
    send(13);
    idle();
    chk("r13_done", pkt_done, 1);
    chk("r13_runt", err_runt, 1);
    chk("r13_len", pkt_len, 13);
    chk("r13_et", ethertype, 0);
    chk("r13_src", src_mac, 48'hAABBCCDDEEFF);

    // single-beat 8 bytes
    send(8);
    idle();
    chk("s8_done", pkt_done, 1);
    chk("s8_runt", err_runt, 1);
    chk("s8_len", pkt_len, 8);
    chk("s8_src", src_mac, 48'hAABB_0000_0000);

    // sop mid-packet, then a full 24-byte packet
    beat(64'hDEADBEEF0001_0203, 8'hFF, 1'b1, 1'b0);
    beat(64'h0405_0607_0800_0000, 8'hFF, 1'b0, 1'b0);
    beat({pb[0], pb[1], pb[2], pb[3], pb[4], pb[5], pb[6], pb[7]}, 8'hFF, 1'b1, 1'b0);
    beat({pb[8], pb[9], pb[10], pb[11], pb[12], pb[13], pb[14], pb[15]}, 8'hFF, 1'b0, 1'b0);
    chk("tr_done", pkt_done, 1);
    chk("tr_trunc", err_trunc, 1);
    chk("tr_len", pkt_len, 16);
    chk("tr_dst", dst_mac, 48'hDEADBEEF0001);
    beat({pb[16], pb[17], pb[18], pb[19], pb[20], pb[21], pb[22], pb[23]}, 8'hFF, 1'b0, 1'b1);
    chk("tr_gap", pkt_done, 0);
    idle();
    chk("b24_done", pkt_done, 1);
    chk("b24_len", pkt_len, 24);
    chk("b24_trunc", err_trunc, 0);
    chk("b24_dst", dst_mac, 48'h112233445566);

    // truncation by a single-beat packet: two consecutive results
    beat(64'h0102030405060708, 8'hFF, 1'b1, 1'b0);
    beat(64'h090A0B0C08000000, 8'hFF, 1'b0, 1'b0);
    beat(64'hCAFEF00D1234_5678, 8'hFF, 1'b1, 1'b1);
    idle();
    chk("pq1_done", pkt_done, 1);
    chk("pq1_trunc", err_trunc, 1);
    chk("pq1_len", pkt_len, 16);
    idle();
    chk("pq2_done", pkt_done, 1);
    chk("pq2_trunc", err_trunc, 0);
    chk("pq2_len", pkt_len, 8);
    chk("pq2_dst", dst_mac, 48'hCAFEF00D1234);
    idle();
    chk("pq_clr", pkt_done, 0);

    // framing error in IDLE
    beat(64'h1111111111111111, 8'hFF, 1'b0, 1'b0);
    idle();
    chk("fe_pulse", framing_err, 1);
    chk("fe_nodone", pkt_done, 0);
    idle();
    chk("fe_clr", framing_err, 0);

    // eop byte_enable A0: non-contiguous, adds 2
    fill_base();
    beat({pb[0], pb[1], pb[2], pb[3], pb[4], pb[5], pb[6], pb[7]}, 8'hFF, 1'b1, 1'b0);
    beat({pb[8], pb[9], pb[10], pb[11], pb[12], pb[13], pb[14], pb[15]}, 8'hFF, 1'b0, 1'b0);
    beat(64'hA1A2A3A4A5A6A7A8, 8'hA0, 1'b0, 1'b1);
    idle();
    chk("be_done", pkt_done, 1);
    chk("be_err", err_be, 1);
    chk("be_len", pkt_len, 18);
    chk("be_runt", err_runt, 0);

    // reset mid-packet
    beat({pb[0], pb[1], pb[2], pb[3], pb[4], pb[5], pb[6], pb[7]}, 8'hFF, 1'b1, 1'b0);
    beat({pb[8], pb[9], pb[10], pb[11], pb[12], pb[13], pb[14], pb[15]}, 8'hFF, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    data = 64'h5555555555555555; valid = 1'b1; sop = 1'b0; eop = 1'b0;
    #1;
    chk("mr_len", pkt_len, 0);
    chk("mr_dst", dst_mac, 0);
    chk("mr_flags", {pkt_done, vlan_present, err_runt, err_trunc, err_be, framing_err}, 0);
    chk("mr_fields", {ethertype, vlan_tci}, 0);
    @(negedge clk);
    rst = 1'b0; valid = 1'b0;
    send(14);
    chk("mr_nostale", pkt_done, 0);
    idle();
    chk("n14_done", pkt_done, 1);
    chk("n14_len", pkt_len, 14);
    chk("n14_runt", err_runt, 0);
    chk("n14_et", ethertype, 16'h0800);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
